arith_bit_packer: RTL and testbench
===================================

Name: arith_bit_packer

Overview:
Sequencer for the arithmetic encoder's variable-length output path. Accepts encoder emissions of 0..16 right-aligned bits per beat, each an output bit plus its pending bits. Packs them MSB-first into 32-bit words and hands the words downstream over a valid/ready handshake. Handles end-of-stream flushing of a partial word and flags illegal lengths.

Parameters:
WORD_W, 32, output word width (fixed at 32; other values unsupported)
MAX_LEN, 16, maximum legal bits per input beat

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat present
in_ready  output  1  block can accept a beat this cycle
in_bits  input  16  payload, right-aligned; in_bits[in_len-1] is the first bit in stream order
in_len  input  5  number of valid bits, 0..16
in_last  input  1  beat is the final beat of the stream
word_valid  output  1  word_data holds a word
word_ready  input  1  downstream accepts the word
word_data  output  32  packed word; first stream bit at bit 31
word_bits  output  6  valid bits in word_data (32 for a full word, 0..31 for the final partial word)
word_last  output  1  word is the last of the stream
err  output  1  sticky flag: an in_len > 16 was seen

Behaviour:
- Reset (async, rst_n=0): state=RUN, acc=0, fill=0, word_valid=0, word_data=0, word_bits=0, word_last=0, err=0. Reset mid-FLUSH or with a word pending discards everything.
- Internal state: acc[31:0] (left-aligned partial word), fill[5:0] (0..31), FSM {RUN, FLUSH}, flag pend_last.
- Output slot: word_valid/word_data/word_bits/word_last are registered. The slot is free when !word_valid || word_ready. Word fields hold stable while word_valid && !word_ready.
- in_ready = (state==RUN) && slot free. Beat accepted on in_valid && in_ready.
- Accept, with len = min(in_len,16) and total = fill+len:
  - total < 32: append bits below acc's existing fill; fill <= total.
  - total >= 32: word_data <= acc | upper (32-fill) bits of the beat; word_bits <= 32; word_valid <= 1. acc <= the remaining (total-32) bits left-aligned, zero below; fill <= total-32.
  - len=0: no data change (in_last still honoured).
- Latency: a word becomes visible (word_valid=1) the cycle after the completing beat is accepted.
- in_last handling on an accepted beat:
  - Resulting fill==0 and a full word was formed: that word carries word_last=1; stay in RUN.
  - Resulting fill>0: go to FLUSH. Any full word formed by that beat carries word_last=0.
  - Resulting fill==0 and no word formed (empty stream or len 0 at fill 0): go to FLUSH. FLUSH emits word_data=0, word_bits=0, word_last=1.
- FLUSH: wait until the slot is free, then load word_data=acc (zero padded), word_bits=fill, word_last=1, word_valid=1. Then acc=0, fill=0, and return to RUN. in_ready=0 throughout FLUSH.
- Handshake: word_valid clears on word_ready unless a new word is loaded in the same cycle. Back-to-back words at one per cycle are supported when word_ready=1.
- in_len 17..31 on an accepted beat: err <= 1 (sticky until reset); the beat is processed as len=16.
- in_valid while in_ready=0: ignored; the source must hold the beat.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. After release, in_ready=1 with word_valid=0.
- Two beats len=16: 0xABCD then 0x1234, word_ready=1 -> next cycle word_data=0xABCD1234, word_bits=32, word_last=0, fill=0.
- Spanning beat: 0xFFFF/16, 0xA/4, 0x5555/16 -> word_data=0xFFFFA555. Residual acc=0x50000000, fill=4.
- Backpressure: word pending with word_ready=0 -> in_ready=0, word_data stable over 5 cycles. Raise word_ready -> in_ready=1 the same cycle; the next word loads without loss.
- Final partial and empty streams: 0x13/5 with in_last -> FLUSH, then word_data=0x98000000, word_bits=5, word_last=1. An exact fill of 32 on in_last -> a single word with word_last=1 and no FLUSH. in_last with len 0 at fill 0 -> word_bits=0, word_last=1.
- Illegal length: in_len=20 with in_bits=0xFFFF at fill 0 -> err=1 and acc=0xFFFF0000; err persists until rst_n=0.

Source files
------------

// File: rtl/arith_bit_packer.sv
// Packs 0..16-bit right-aligned encoder emissions MSB-first into 32-bit words,
// with end-of-stream flush of a partial word and a sticky illegal-length flag.
module arith_bit_packer #(
    parameter int WORD_W  = 32,
    parameter int MAX_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_LEN-1:0] in_bits,
    input  logic [4:0]         in_len,
    input  logic               in_last,
    output logic               word_valid,
    input  logic               word_ready,
    output logic [WORD_W-1:0]  word_data,
    output logic [5:0]         word_bits,
    output logic               word_last,
    output logic               err
);

    // Handshake: a beat moves when in_valid && in_ready; a word moves when
    // word_valid && word_ready. Word fields never change while stalled.

    typedef enum logic [0:0] {RUN, FLUSH} state_e;

    localparam logic [4:0] MAX_LEN_L = 5'(MAX_LEN);
    localparam logic [5:0] WORD_W_L  = 6'(WORD_W);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [5:0]          fill_q, fill_d;
    logic                word_valid_q, word_valid_d;
    logic [WORD_W-1:0]   word_data_q, word_data_d;
    logic [5:0]          word_bits_q, word_bits_d;
    logic                word_last_q, word_last_d;
    logic                err_q, err_d;

    logic                slot_free;
    logic                in_ready_c;
    logic                accept;
    logic [4:0]          len;
    logic [5:0]          total;
    logic [MAX_LEN:0]    mask;
    logic [MAX_LEN:0]    masked;
    logic [6:0]          shamt;
    logic [2*WORD_W-1:0] beat_sh;
    logic [2*WORD_W-1:0] merged;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        word_valid_d = word_valid_q;
        word_data_d  = word_data_q;
        word_bits_d  = word_bits_q;
        word_last_d  = word_last_q;
        err_d        = err_q;

        slot_free  = !word_valid_q || word_ready;
        in_ready_c = (state_q == RUN) && slot_free;
        accept     = in_valid && in_ready_c;

        // Beat bits are placed in a double-width window directly below the
        // current fill, so the upper half is the next word and the lower half
        // is the left-aligned remainder.
        len     = (in_len > MAX_LEN_L) ? MAX_LEN_L : in_len;
        total   = fill_q + 6'(len);
        mask    = ((MAX_LEN+1)'(1) << len) - (MAX_LEN+1)'(1);
        masked  = {1'b0, in_bits} & mask;
        shamt   = 7'(2*WORD_W) - 7'(total);
        beat_sh = (2*WORD_W)'(masked) << shamt;
        merged  = {acc_q, {WORD_W{1'b0}}} | beat_sh;

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        if (accept) begin
            if (in_len > MAX_LEN_L) begin
                err_d = 1'b1;
            end
            if (total >= WORD_W_L) begin
                word_data_d  = merged[2*WORD_W-1:WORD_W];
                word_bits_d  = WORD_W_L;
                word_valid_d = 1'b1;
                word_last_d  = in_last && (total == WORD_W_L);
                acc_d        = merged[WORD_W-1:0];
                fill_d       = total - WORD_W_L;
            end else begin
                acc_d  = merged[2*WORD_W-1:WORD_W];
                fill_d = total;
            end
            // Only an exact word boundary lets the last beat finish without a flush word.
            if (in_last && (total != WORD_W_L)) begin
                state_d = FLUSH;
            end
        end else if ((state_q == FLUSH) && slot_free) begin
            word_data_d  = acc_q;
            word_bits_d  = fill_q;
            word_last_d  = 1'b1;
            word_valid_d = 1'b1;
            acc_d        = '0;
            fill_d       = '0;
            state_d      = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            acc_q        <= '0;
            fill_q       <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_bits_q  <= '0;
            word_last_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_bits_q  <= word_bits_d;
            word_last_q  <= word_last_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_c;
    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign word_bits  = word_bits_q;
    assign word_last  = word_last_q;
    assign err        = err_q;

endmodule

// File: tb/tb_arith_bit_packer.sv
// Directed bench for arith_bit_packer: reset, backpressure, a table of beats
// with hand-computed words, flush corner cases and the sticky length error.
module tb_arith_bit_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bits;
    logic [4:0]  in_len;
    logic        in_last;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic [5:0]  word_bits;
    logic        word_last;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    arith_bit_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bits    (in_bits),
        .in_len     (in_len),
        .in_last    (in_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_bits  (word_bits),
        .word_last  (word_last),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        logic [4:0]  len;
        logic        last;
        logic        v;
        logic [31:0] d;
        logic [5:0]  wb;
        logic        wl;
        logic        hf;
        logic [31:0] fd;
        logic [5:0]  fb;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts and ends just after a falling edge; returns right after the accept.
    task automatic send(input logic [15:0] b, input logic [4:0] l, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_bits  = b;
        in_len   = l;
        in_last  = last;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck low for beat %h/%0d", b, l);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{16'hABCD, 5'd16, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0, 32'h0,        6'd0};
        vecs[1]  = '{16'h1234, 5'd16, 1'b0, 1'b1, 32'hABCD1234, 6'd32, 1'b0, 1'b0, 32'h0,        6'd0};
        vecs[2]  = '{16'hFFFF, 5'd16, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0, 32'h0,        6'd0};
        vecs[3]  = '{16'h000A, 5'd4,  1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0, 32'h0,        6'd0};
        vecs[4]  = '{16'h5555, 5'd16, 1'b0, 1'b1, 32'hFFFFA555, 6'd32, 1'b0, 1'b0, 32'h0,        6'd0};
        vecs[5]  = '{16'h0000, 5'd0,  1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b1, 32'h50000000, 6'd4};
        vecs[6]  = '{16'h0013, 5'd5,  1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b1, 32'h98000000, 6'd5};
        vecs[7]  = '{16'hFFFF, 5'd16, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0, 32'h0,        6'd0};
        vecs[8]  = '{16'h0001, 5'd16, 1'b1, 1'b1, 32'hFFFF0001, 6'd32, 1'b1, 1'b0, 32'h0,        6'd0};
        vecs[9]  = '{16'h0000, 5'd0,  1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b1, 32'h0,        6'd0};
        vecs[10] = '{16'hFFF8, 5'd3,  1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0, 32'h0,        6'd0};
        vecs[11] = '{16'h0000, 5'd13, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0, 32'h0,        6'd0};
        vecs[12] = '{16'hBEEF, 5'd16, 1'b0, 1'b1, 32'h0000BEEF, 6'd32, 1'b0, 1'b0, 32'h0,        6'd0};
        vecs[13] = '{16'h7FFF, 5'd15, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0, 32'h0,        6'd0};
        vecs[14] = '{16'hFFFF, 5'd16, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0, 32'h0,        6'd0};
        vecs[15] = '{16'h8001, 5'd16, 1'b0, 1'b1, 32'hFFFFFFFF, 6'd32, 1'b0, 1'b0, 32'h0,        6'd0};
        vecs[16] = '{16'h0001, 5'd1,  1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b1, 32'h00030000, 6'd16};
        vecs[17] = '{16'hAAAA, 5'd16, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0, 32'h0,        6'd0};
        vecs[18] = '{16'h00FF, 5'd12, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0, 32'h0,        6'd0};
        vecs[19] = '{16'hF0F0, 5'd16, 1'b1, 1'b1, 32'hAAAA0FFF, 6'd32, 1'b0, 1'b1, 32'h0F000000, 6'd12};
        vecs[20] = '{16'h1234, 5'd16, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0, 32'h0,        6'd0};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_bits    = '0;
        in_len     = '0;
        in_last    = 1'b0;
        word_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_word_valid", 32'(word_valid), 32'd0);
        chk("post_reset_err", 32'(err), 32'd0);

        // Backpressure: a word stalls, the next beat waits without being lost.
        send(16'h1111, 5'd16, 1'b0);
        send(16'h2222, 5'd16, 1'b0);
        chk("bp_word_valid", 32'(word_valid), 32'd1);
        chk("bp_word_data", word_data, 32'h11112222);
        in_valid = 1'b1;
        in_bits  = 16'h3333;
        in_len   = 5'd16;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_data_stable", word_data, 32'h11112222);
            @(negedge clk);
        end
        word_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_word_drained", 32'(word_valid), 32'd0);
        send(16'h4444, 5'd16, 1'b0);
        chk("bp_next_valid", 32'(word_valid), 32'd1);
        chk("bp_next_data", word_data, 32'h33334444);
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            send(vecs[i].bits, vecs[i].len, vecs[i].last);
            chk($sformatf("v%0d_valid", i), 32'(word_valid), 32'(vecs[i].v));
            if (vecs[i].v) begin
                chk($sformatf("v%0d_data", i), word_data, vecs[i].d);
                chk($sformatf("v%0d_bits", i), 32'(word_bits), 32'(vecs[i].wb));
                chk($sformatf("v%0d_last", i), 32'(word_last), 32'(vecs[i].wl));
            end
            chk($sformatf("v%0d_err", i), 32'(err), 32'd0);
            if (vecs[i].hf) begin
                @(negedge clk);
                chk($sformatf("v%0d_flush_valid", i), 32'(word_valid), 32'd1);
                chk($sformatf("v%0d_flush_data", i), word_data, vecs[i].fd);
                chk($sformatf("v%0d_flush_bits", i), 32'(word_bits), 32'(vecs[i].fb));
                chk($sformatf("v%0d_flush_last", i), 32'(word_last), 32'd1);
            end
        end
        @(negedge clk);

        // Illegal length is processed as 16 bits and latches err.
        send(16'hFFFF, 5'd20, 1'b0);
        chk("illegal_err", 32'(err), 32'd1);
        send(16'h0000, 5'd0, 1'b1);
        chk("illegal_no_word", 32'(word_valid), 32'd0);
        @(negedge clk);
        chk("illegal_flush_valid", 32'(word_valid), 32'd1);
        chk("illegal_flush_data", word_data, 32'hFFFF0000);
        chk("illegal_flush_bits", 32'(word_bits), 32'd16);
        chk("illegal_err_sticky", 32'(err), 32'd1);
        @(negedge clk);

        // Asynchronous reset mid-cycle with a word pending.
        word_ready = 1'b0;
        send(16'hAAAA, 5'd16, 1'b0);
        send(16'hBBBB, 5'd16, 1'b0);
        chk("pre_reset_pending", 32'(word_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_word_valid", 32'(word_valid), 32'd0);
        chk("async_word_data", word_data, 32'd0);
        chk("async_word_bits", 32'(word_bits), 32'd0);
        chk("async_word_last", 32'(word_last), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerelease_in_ready", 32'(in_ready), 32'd1);
        chk("rerelease_word_valid", 32'(word_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
